reg_bank_reader: RTL and testbench

REG_BANK_READER -- requirements
Module: reg_bank_reader

---
 rtl/reg_bank_reader.sv | 138 +++++++++++++
 tb/tb_reg_bank_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// Burst reader: streams a wrapping run of register-bank words into a 3-deep
// output FIFO with ready/valid back-pressure on the sink side.
module reg_bank_reader #(
  parameter int N     = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          test_mode_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic [AW-1:0] req_len_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [N-1:0]  rd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_data_o,
  output logic          out_last_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   REM_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1'b1);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     remaining_q, remaining_d;
  logic            inflight_q, inflight_last_q;
  logic [N-1:0]    fifo_data_q [3];
  logic [2:0]      fifo_last_q;
  logic [1:0]      wr_ptr_q, rd_ptr_q, count_q;

  logic            issue_s, pop_s, push_s, valid_s, head_last_s;
  logic [2:0]      occupancy_s;

  assign valid_s     = (count_q != 2'd0);
  assign head_last_s = fifo_last_q[rd_ptr_q];
  assign pop_s       = valid_s && out_ready_i;
  assign push_s      = inflight_q;
  // Words already buffered plus the one returning next cycle bound new issues.
  assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_q};

  // Next-state, address/remaining bookkeeping and read issue decision.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !test_mode_i) begin
          addr_d      = req_addr_i;
          remaining_d = {1'b0, req_len_i} + REM_ONE;
          state_d     = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if ((remaining_q != '0) && (occupancy_s < 3'd3)) begin
          issue_s     = 1'b1;
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          state_d     = (remaining_q == REM_ONE) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (pop_s && head_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, in-flight tracking and FIFO storage.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 2'd0;
      fifo_last_q     <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue_s;
      inflight_last_q <= issue_s && (remaining_q == REM_ONE);
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= rd_data_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE) && !test_mode_i;
  assign rd_en_o     = issue_s;
  assign rd_addr_o   = addr_q;
  assign out_valid_o = valid_s;
  assign out_data_o  = valid_s ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last_o  = valid_s && head_last_s;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_reader.sv
// Randomised and directed bench for reg_bank_reader, checked against a
// queue-based model of the expected word stream.
module tb_reg_bank_reader;
  localparam int N = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset, test_mode, req_valid, req_ready, rd_en, out_valid, out_ready, out_last, busy;
  logic [AW-1:0] req_addr, req_len, rd_addr;
  logic [N-1:0] rd_data, out_data;

  reg_bank_reader #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .test_mode_i(test_mode),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last), .busy_o(busy)
  );

  initial forever #5 clk = ~clk;

  logic [N-1:0] bank [DEPTH];
  always @(posedge clk) rd_data <= rd_en ? bank[rd_addr] : N'($urandom);

  typedef struct { logic [N-1:0] d; logic l; } word_t;
  word_t exp_q[$];
  logic [N-1:0] cap[$];
  logic cap_last[$];
  bit m_busy, stall_prev, rand_rdy;
  int m_issued, m_popped, m_total;
  logic [AW-1:0] m_next;
  logic [N-1:0] stall_data;
  int tests = 0, fails = 0;
  logic s_rd_en, s_out_valid, s_out_last, s_busy, s_req_ready;
  logic [AW-1:0] s_rd_addr;
  logic [N-1:0] s_out_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at negedge, check against the model, then advance.
  task automatic step();
    word_t w;
    bit was_busy;
    @(negedge clk);
    s_rd_en = rd_en; s_rd_addr = rd_addr; s_out_valid = out_valid;
    s_out_data = out_data; s_out_last = out_last; s_busy = busy; s_req_ready = req_ready;
    if (!reset) begin
      exp_q.delete(); m_busy = 1'b0; stall_prev = 1'b0;
      m_issued = 0; m_popped = 0; m_total = 0;
    end else begin
      was_busy = m_busy;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("req_ready", 32'(req_ready), 32'(!m_busy && !test_mode));
      if (out_valid) chk("valid_owed", 32'(exp_q.size() != 0), 32'd1);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (rd_en) begin
        chk("rd_en_window", 32'(m_busy && (m_issued < m_total)), 32'd1);
        chk("rd_addr", 32'(rd_addr), 32'(m_next));
        chk("outstanding", 32'((m_issued - m_popped) < 3), 32'd1);
        m_next = m_next + AW'(1);
        m_issued++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_word: got %0d expected none", out_data);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(w.d));
          chk("out_last", 32'(out_last), 32'(w.l));
          cap.push_back(out_data);
          cap_last.push_back(out_last);
          m_popped++;
          if (w.l) begin
            chk("reads_issued", 32'(m_issued), 32'(m_total));
            m_busy = 1'b0;
          end
        end
      end
      if (req_valid && !was_busy && !test_mode) begin
        m_total = int'(req_len) + 1;
        for (int k = 0; k < m_total; k++) begin
          w.d = bank[req_addr + AW'(k)];
          w.l = (k == m_total - 1);
          exp_q.push_back(w);
        end
        m_next = req_addr; m_issued = 0; m_popped = 0; m_busy = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && m_busy; i++) step();
    chk("burst_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic wait_valid();
    int i = 0;
    do begin step(); i++; end while (!s_out_valid && i < 20);
    chk("first_valid_timeout", 32'(s_out_valid), 32'd1);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [AW-1:0] l);
    req_addr = a; req_len = l; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] en_v, val_v, last_v;
    logic [N-1:0] dat [9];
    logic [AW-1:0] adr [9];
    logic [N-1:0] e36 [4];
    int base, nrd;

    reset = 1'b0; test_mode = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    out_ready = 1'b1; rand_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) bank[i] = N'(i);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_req_ready", 32'(s_req_ready), 32'd1);
    chk("rst_rd_en", 32'(s_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(s_rd_addr), 32'd0);
    chk("rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_out_data", 32'(s_out_data), 32'd0);
    chk("rst_out_last", 32'(s_out_last), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);

    // Cycle-accurate pin: addr 3, len 3.
    start(4'd3, 4'd3);
    en_v = '0; val_v = '0; last_v = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      en_v[k] = s_rd_en; val_v[k] = s_out_valid; last_v[k] = s_out_last;
      dat[k] = s_out_data; adr[k] = s_rd_addr;
      if (k == 6) chk("d35_busy6", 32'(s_busy), 32'd1);
      if (k == 7) begin
        chk("d35_busy7", 32'(s_busy), 32'd0);
        chk("d35_ready7", 32'(s_req_ready), 32'd1);
      end
    end
    chk("d35_rd_en_cycles", 32'(en_v), 32'h01E);
    chk("d35_valid_cycles", 32'(val_v), 32'h078);
    chk("d35_last_cycles", 32'(last_v), 32'h040);
    for (int k = 1; k <= 4; k++) chk("d35_rd_addr", 32'(adr[k]), 32'(k + 2));
    for (int k = 3; k <= 6; k++) chk("d35_out_data", 32'(dat[k]), 32'(k));

    // Wrap: addr 14, len 3.
    e36[0] = 4'd14; e36[1] = 4'd15; e36[2] = 4'd0; e36[3] = 4'd1;
    base = cap.size();
    start(4'd14, 4'd3);
    wait_done();
    chk("d36_count", 32'(cap.size() - base), 32'd4);
    for (int j = 0; j < 4 && base + j < cap.size(); j++) chk("d36_word", 32'(cap[base+j]), 32'(e36[j]));
    if (cap_last.size() >= base + 4) chk("d36_last", 32'(cap_last[base+3]), 32'd1);

    // Stall: out_ready low for 5 cycles after first data.
    base = cap.size();
    out_ready = 1'b0;
    start(4'd0, 4'd7);
    wait_valid();
    nrd = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      nrd += int'(s_rd_en);
      chk("d37_held_data", 32'(s_out_data), 32'd0);
    end
    chk("d37_reads_in_stall", 32'(nrd <= 3), 32'd1);
    out_ready = 1'b1;
    wait_done();
    chk("d37_count", 32'(cap.size() - base), 32'd8);
    for (int j = 0; j < 8 && base + j < cap.size(); j++) chk("d37_word", 32'(cap[base+j]), 32'(j));

    // test_mode blocks acceptance, but not a running burst.
    test_mode = 1'b1; req_addr = 4'd2; req_len = 4'd2; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("d38_ready_blocked", 32'(s_req_ready), 32'd0);
      chk("d38_no_rd_en", 32'(s_rd_en), 32'd0);
    end
    req_valid = 1'b0; test_mode = 1'b0;
    base = cap.size();
    start(4'd8, 4'd7);
    step(); step();
    test_mode = 1'b1;
    wait_done();
    chk("d38_count", 32'(cap.size() - base), 32'd8);
    for (int j = 0; j < 8 && base + j < cap.size(); j++) chk("d38_word", 32'(cap[base+j]), 32'(j + 8));
    test_mode = 1'b0;
    step();

    // Reset mid-burst, then a single-word burst.
    start(4'd0, 4'd7);
    wait_valid();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("d39_valid", 32'(s_out_valid), 32'd0);
    chk("d39_busy", 32'(s_busy), 32'd0);
    chk("d39_rd_en", 32'(s_rd_en), 32'd0);
    base = cap.size();
    start(4'd5, 4'd0);
    wait_done();
    chk("d39_count", 32'(cap.size() - base), 32'd1);
    if (cap.size() > base) begin
      chk("d39_word", 32'(cap[base]), 32'd5);
      chk("d39_last", 32'(cap_last[base]), 32'd1);
    end

    // Randomised bursts with random back-pressure, test_mode and idle requests.
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < DEPTH; i++) bank[i] = N'($urandom);
      req_addr = AW'($urandom);
      req_len = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 5));
      req_valid = 1'b1;
      for (int i = 0; i < 30 && !m_busy; i++) begin
        test_mode = (i < 5) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        step();
      end
      chk("rnd_accept", 32'(m_busy), 32'd1);
      for (int i = 0; i < 400 && m_busy; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        test_mode = 1'($urandom_range(0, 3) == 0);
        step();
      end
      chk("rnd_timeout", 32'(m_busy), 32'd0);
      req_valid = 1'b0;
    end
    rand_rdy = 1'b0; out_ready = 1'b1; test_mode = 1'b0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
